// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush controller for the 5-stage pipeline. Decides, every
//   cycle, which pipeline register arrays load, which load a bubble, and
//   whether the PC advances. Three hazard sources, highest priority first:
//     1. multi-cycle MUL/DIV occupying EX (md FSM)
//     2. taken branch/jump resolved in EX (redirect, squash IF/ID and ID/EX)
//     3. load-use dependency between the load in EX and the instruction in ID
//   Also keeps two wrapping 32-bit performance counters.
//
//   State updates on posedge clk. All control outputs are combinational, so
//   they settle before the negedge at which the pipeline registers sample.
//
// Ports
//   clk              system clock
//   Rst              asynchronous, active-low reset
//   id_rs, id_rt     source register numbers of the ID instruction
//   id_use_rs/rt     ID instruction actually reads rs / rt
//   ex_mem_read      EX instruction is a load
//   ex_wr_reg        EX destination register number
//   ex_branch_taken  branch/jump resolved taken in EX
//   ex_md_start      EX holds a MUL/DIV op
//   ex_md_is_div     1 = DIV latency, 0 = MUL latency (sampled with start)
//   perf_clr         synchronous clear of both perf counters
//   pc_we            PC write enable
//   *_we / *_flush   pipeline register write enable / load-bubble
//   md_busy          MUL/DIV FSM is in BUSY (this is the FSM's full state)
//   md_done          one-cycle pulse: MD op leaves EX this cycle
//   stall_count      cycles with pc_we = 0
//   flush_count      cycles with ifid_flush = 1
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_wr_reg,
  input  logic        ex_branch_taken,
  input  logic        ex_md_start,
  input  logic        ex_md_is_div,
  input  logic        perf_clr,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_we,
  output logic        idex_flush,
  output logic        exmem_we,
  output logic        exmem_flush,
  output logic        memwb_we,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // The start cycle stalls, then cnt counts LAT-2 .. 0 in BUSY; the cycle
  // with cnt==0 releases EX. Total stall = LAT-1 cycles.
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 2);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_stall;
  logic             md_done_c;
  logic             load_use;

  // ---------------- MUL/DIV occupancy FSM ----------------
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_stall  = 1'b0;
    md_done_c = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (ex_md_start) begin
          md_stall = 1'b1;
          cnt_d    = ex_md_is_div ? DIV_INIT : MUL_INIT;
          state_d  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        // ex_md_start stays high while the op is held, so it is not looked at here.
        if (cnt_q != '0) begin
          md_stall = 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end else begin
          md_done_c = 1'b1;
          state_d   = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign md_busy = (state_q == MD_BUSY);

  // Register $0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_wr_reg != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_wr_reg)) ||
                     (id_use_rt && (id_rt == ex_wr_reg)));

  // ---------------- pipeline control ----------------
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_we     = 1'b0;
    idex_flush  = 1'b0;
    exmem_we    = 1'b0;
    exmem_flush = 1'b0;
    memwb_we    = 1'b0;
    md_done     = 1'b0;
    if (Rst) begin
      pc_we    = 1'b1;
      ifid_we  = 1'b1;
      idex_we  = 1'b1;
      exmem_we = 1'b1;
      memwb_we = 1'b1;
      md_done  = md_done_c;
      if (md_stall) begin
        // Freeze IF/ID/EX; the stage after EX receives bubbles while MEM/WB drain.
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_flush = 1'b1;
      end else if (ex_branch_taken) begin
        // Redirect: the two younger instructions are wrong-path, so any
        // load-use hazard they show is irrelevant.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // ---------------- performance counters ----------------
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (perf_clr) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      stall_count <= stall_count + {31'd0, ~pc_we};
      flush_count <= flush_count + {31'd0, ifid_flush};
    end
  end

endmodule
